// File: rtl/fixed_sqrt_pkg.sv
// Shared constants, FSM state type and start-pair helper for the seeded square root.
package fixed_sqrt_pkg;

  localparam int unsigned FRAC_BITS = 4;
  localparam int unsigned CNT_W     = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // First radicand pair to process: skips pairs above the seeded integer MSB.
  // Fraction-only operands start at the top pair of the 2*FRAC_BITS fraction field.
  function automatic logic [CNT_W-1:0] start_pair(
    input logic [5:0]  loc,
    input logic        loc_valid,
    input int unsigned rw
  );
    int unsigned sp;
    if (loc_valid) begin
      sp = 32'(loc) + FRAC_BITS;
      if (sp > rw - 1) sp = rw - 1;
    end else begin
      sp = FRAC_BITS - 1;
    end
    return CNT_W'(sp);
  endfunction

endpackage

// File: rtl/sqrt_step.sv
// One combinational digit-by-digit square root iteration over a single radicand pair.
module sqrt_step #(
  parameter int unsigned RW = 8
) (
  input  logic [RW+1:0] rem_in,
  input  logic [RW-1:0] root_in,
  input  logic [1:0]    pair,
  output logic [RW+1:0] rem_out,
  output logic [RW-1:0] root_out
);

  localparam int unsigned TW = RW + 4;

  logic [TW-1:0] t_c;
  logic [TW-1:0] trial_c;
  logic          ge_c;

  // Trial subtraction of (root<<2)|1 from the shifted-in partial remainder.
  always_comb begin
    t_c      = {rem_in, pair};
    trial_c  = {2'b00, root_in, 2'b01};
    ge_c     = (t_c >= trial_c);
    rem_out  = ge_c ? (RW+2)'(t_c - trial_c) : (RW+2)'(t_c);
    root_out = {root_in[RW-2:0], ge_c};
  end

endmodule

// File: rtl/fixed_sqrt_seeded.sv
// Iterative fixed-point square root, seeded by the leading-set-bit location to skip zero pairs.
module fixed_sqrt_seeded
  import fixed_sqrt_pkg::*;
#(
  parameter int unsigned WIDTH = 12
) (
  input  logic                            clk,
  input  logic                            rst_,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [WIDTH-1:0]                in_vector,
  input  logic [5:0]                      in_location,
  input  logic                            in_location_valid,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [(WIDTH+FRAC_BITS)/2-1:0]  out_root,
  output logic                            out_exact
);

  localparam int unsigned RW   = (WIDTH + FRAC_BITS) / 2;
  localparam int unsigned RADW = 2 * RW;
  localparam int unsigned REMW = RW + 2;
  localparam int unsigned IDXW = $clog2(RADW);

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [RADW-1:0]   rad_q;
  logic [REMW-1:0]   rem_q;
  logic [RW-1:0]     root_q;

  logic [IDXW-1:0]   idx_c;
  logic [1:0]        pair_c;
  logic [REMW-1:0]   rem_nx_c;
  logic [RW-1:0]     root_nx_c;

  // Select the radicand pair addressed by the iteration counter.
  always_comb begin
    idx_c  = IDXW'({cnt_q, 1'b0});
    pair_c = rad_q[idx_c +: 2];
  end

  sqrt_step #(
    .RW (RW)
  ) u_step (
    .rem_in   (rem_q),
    .root_in  (root_q),
    .pair     (pair_c),
    .rem_out  (rem_nx_c),
    .root_out (root_nx_c)
  );

  // Control FSM, datapath registers and registered handshake/result outputs.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rad_q     <= '0;
      rem_q     <= '0;
      root_q    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_root  <= '0;
      out_exact <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            rad_q    <= {in_vector, FRAC_BITS'(0)};
            rem_q    <= '0;
            root_q   <= '0;
            cnt_q    <= start_pair(in_location, in_location_valid, RW);
            in_ready <= 1'b0;
            state_q  <= CALC;
          end
        end
        CALC: begin
          rem_q  <= rem_nx_c;
          root_q <= root_nx_c;
          if (cnt_q == '0) begin
            out_root  <= root_nx_c;
            out_exact <= (rem_nx_c == '0);
            out_valid <= 1'b1;
            state_q   <= DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_sqrt_seeded.sv
// Self-checking bench for fixed_sqrt_seeded (WIDTH=12): vector table, random seeded ops, backpressure and reset.
module tb_fixed_sqrt_seeded;

  localparam int unsigned WIDTH = 12;
  localparam int unsigned RW    = 8;

  logic             clk;
  logic             rst_;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_vector;
  logic [5:0]       in_location;
  logic             in_location_valid;
  logic             out_valid;
  logic             out_ready;
  logic [RW-1:0]    out_root;
  logic             out_exact;

  typedef struct {
    logic [WIDTH-1:0] vec;
    logic [5:0]       loc;
    logic             lv;
    logic [RW-1:0]    root;
    logic             exact;
    int               lat;
    int               hold;
  } vec_t;

  typedef struct {
    logic [RW-1:0] root;
    logic          exact;
    int            lat;
  } exp_t;

  exp_t sbq[$];
  vec_t tbl[6];
  int   passed = 0;
  int   total  = 0;

  fixed_sqrt_seeded #(.WIDTH(WIDTH)) dut (
    .clk               (clk),
    .rst_              (rst_),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_vector         (in_vector),
    .in_location       (in_location),
    .in_location_valid (in_location_valid),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_root          (out_root),
    .out_exact         (out_exact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got hang expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference square root by exhaustive search over the Q.4 radicand.
  function automatic logic [RW-1:0] model_root(input logic [WIDTH-1:0] v);
    int unsigned r_big = 32'({v, 4'b0000});
    int unsigned r = 0;
    while ((r + 1) * (r + 1) <= r_big) r++;
    return RW'(r);
  endfunction

  function automatic logic model_exact(input logic [WIDTH-1:0] v);
    int unsigned r_big = 32'({v, 4'b0000});
    int unsigned r = 32'(model_root(v));
    return (r * r == r_big);
  endfunction

  // Offer one operand at a negedge; the accept edge pushes its expectation.
  task automatic issue(input string name, input logic [WIDTH-1:0] v, input logic [5:0] loc,
                       input logic lv, input logic [RW-1:0] r, input logic ex, input int lat);
    exp_t e;
    chk({name, "_in_ready_idle"}, 32'(in_ready), 32'd1);
    in_vector         = v;
    in_location       = loc;
    in_location_valid = lv;
    in_valid          = 1'b1;
    @(posedge clk);
    e.root  = r;
    e.exact = ex;
    e.lat   = lat;
    sbq.push_back(e);
    #1;
    in_valid          = 1'b0;
    in_vector         = WIDTH'($urandom);
    in_location       = 6'($urandom);
    in_location_valid = 1'($urandom);
    chk({name, "_in_ready_busy"}, 32'(in_ready), 32'd0);
  endtask

  // Wait (bounded) for the result, compare against the scoreboard, then hold and release.
  task automatic collect(input string name, input int hold);
    int   n = 0;
    exp_t e;
    while (out_valid !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sbq.size() == 0) begin
      chk({name, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sbq.pop_front();
    if (out_valid !== 1'b1) begin
      chk({name, "_timeout"}, 32'(out_valid), 32'd1);
      return;
    end
    chk({name, "_latency"}, 32'(n), 32'(e.lat));
    chk({name, "_root"}, 32'(out_root), 32'(e.root));
    chk({name, "_exact"}, 32'(out_exact), 32'(e.exact));
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      in_valid  = ~in_valid;
      in_vector = WIDTH'($urandom);
      @(posedge clk);
      #1;
      chk({name, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({name, "_hold_root"}, 32'(out_root), 32'(e.root));
      chk({name, "_hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({name, "_post_valid"}, 32'(out_valid), 32'd0);
    chk({name, "_post_in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    tbl[0] = '{vec: 12'h100, loc: 6'd2, lv: 1'b1, root: 8'h40, exact: 1'b1, lat: 7, hold: 0};
    tbl[1] = '{vec: 12'h020, loc: 6'd0, lv: 1'b1, root: 8'h16, exact: 1'b0, lat: 5, hold: 10};
    tbl[2] = '{vec: 12'h000, loc: 6'd0, lv: 1'b0, root: 8'h00, exact: 1'b1, lat: 4, hold: 0};
    tbl[3] = '{vec: 12'h004, loc: 6'd0, lv: 1'b0, root: 8'h08, exact: 1'b1, lat: 4, hold: 0};
    tbl[4] = '{vec: 12'hFFF, loc: 6'd4, lv: 1'b1, root: 8'hFF, exact: 1'b0, lat: 8, hold: 0};
    tbl[5] = '{vec: 12'hFFF, loc: 6'd7, lv: 1'b1, root: 8'hFF, exact: 1'b0, lat: 8, hold: 0};

    rst_              = 1'b0;
    in_valid          = 1'b0;
    in_vector         = '0;
    in_location       = '0;
    in_location_valid = 1'b0;
    out_ready         = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_root", 32'(out_root), 32'd0);
    chk("rst_out_exact", 32'(out_exact), 32'd0);
    @(negedge clk);
    rst_ = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      issue(nm, tbl[i].vec, tbl[i].loc, tbl[i].lv, tbl[i].root, tbl[i].exact, tbl[i].lat);
      collect(nm, tbl[i].hold);
    end

    // Random operands with a correct or over-large seed.
    for (int i = 0; i < 10; i++) begin
      logic [WIDTH-1:0] v;
      logic [7:0]       ip;
      logic [5:0]       loc;
      logic             lv;
      int               hi;
      int               sp;
      string            nm;
      v  = WIDTH'($urandom);
      ip = v[WIDTH-1:4];
      hi = -1;
      for (int b = 0; b < 8; b++) if (ip[b]) hi = b;
      lv  = (hi >= 0);
      loc = lv ? 6'(hi / 2 + int'($urandom_range(0, 2))) : 6'($urandom_range(0, 63));
      sp  = lv ? ((4 + int'(loc)) > 7 ? 7 : 4 + int'(loc)) : 3;
      nm  = $sformatf("rnd%0d", i);
      issue(nm, v, loc, lv, model_root(v), model_exact(v), sp + 1);
      collect(nm, 0);
    end

    // Reset in the middle of a computation discards it.
    issue("rstcalc", 12'h100, 6'd2, 1'b1, 8'h40, 1'b1, 7);
    repeat (3) @(posedge clk);
    #1;
    rst_ = 1'b0;
    #1;
    chk("rstcalc_in_ready", 32'(in_ready), 32'd1);
    chk("rstcalc_out_valid", 32'(out_valid), 32'd0);
    chk("rstcalc_out_root", 32'(out_root), 32'd0);
    chk("rstcalc_out_exact", 32'(out_exact), 32'd0);
    sbq.delete();
    repeat (8) begin
      @(posedge clk);
      #1;
      chk("rstcalc_no_valid", 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    rst_ = 1'b1;
    @(negedge clk);
    issue("after_rst", 12'h090, 6'd2, 1'b1, 8'h30, 1'b1, 7);
    collect("after_rst", 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
